// File: rtl/menu_select_if.sv
// rtl/menu_select_if.sv - vga_if timing + rgb bundle passed between VGA chain stages
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/menu_select.sv
// rtl/menu_select.sv - menu highlight frame + up/down/enter selection with choice handshake (option: MENU_SELECT_BLINK_EN)
module menu_select #(
    parameter int          N_ITEMS     = 3,
    parameter int          ITEM_X      = 312,
    parameter int          ITEM_Y0     = 200,
    parameter int          ITEM_W      = 400,
    parameter int          ITEM_H      = 64,
    parameter int          ITEM_PITCH  = 96,
    parameter int          FRAME_W     = 4,
    parameter logic [11:0] FRAME_COLOR = 12'hFF0,
`ifdef MENU_SELECT_BLINK_EN
    parameter int          BLINK_FRAMES = 30,
`endif
    localparam int         IW          = $clog2(N_ITEMS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_enter,
    input  logic          choice_ack,
    output logic          choice_valid,
    output logic [IW-1:0] choice_idx,
    vga_if.in             in,
    vga_if.out            out
);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_ITEMS - 1);
    localparam logic [10:0]   Y0_C     = 11'(ITEM_Y0);
    localparam logic [10:0]   Y_LAST_C = 11'(ITEM_Y0 + (N_ITEMS - 1) * ITEM_PITCH);
    localparam logic [10:0]   PITCH_C  = 11'(ITEM_PITCH);
    localparam logic [10:0]   X_L      = 11'(ITEM_X);
    localparam logic [10:0]   X_R      = 11'(ITEM_X + ITEM_W);
    localparam logic [10:0]   XI_L     = 11'(ITEM_X + FRAME_W);
    localparam logic [10:0]   XI_R     = 11'(ITEM_X + ITEM_W - FRAME_W);

    typedef enum logic [1:0] {NAV, PEND, LOCKED} state_t;

    state_t        state, state_nxt;
    logic          up_prev, down_prev, enter_prev, vblnk_prev;
    logic          up_ev, down_ev, enter_ev, vblnk_rise;
    logic          dir_down, dir_nxt;
    logic          do_move, do_latch, do_release;
    logic [IW-1:0] sel_idx;
    logic [10:0]   sel_top, y_bot, yi_top, yi_bot;
    logic          in_outer, in_inner, draw_en;
    logic [11:0]   rgb_nxt;

    assign up_ev      = btn_up    & ~up_prev;
    assign down_ev    = btn_down  & ~down_prev;
    assign enter_ev   = btn_enter & ~enter_prev;
    assign vblnk_rise = in.vblnk  & ~vblnk_prev;

    always_comb begin
        state_nxt  = state;
        dir_nxt    = dir_down;
        do_move    = 1'b0;
        do_latch   = 1'b0;
        do_release = 1'b0;
        case (state)
            NAV: begin
                if (enter_ev) begin
                    do_latch  = 1'b1;
                    state_nxt = LOCKED;
                end else if (up_ev ^ down_ev) begin
                    dir_nxt   = down_ev;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (enter_ev) begin
                    do_latch  = 1'b1;
                    state_nxt = LOCKED;
                end else if (vblnk_rise) begin
                    do_move   = 1'b1;
                    state_nxt = NAV;
                end
            end
            LOCKED: begin
                if (choice_valid && choice_ack) begin
                    do_release = 1'b1;
                    state_nxt  = NAV;
                end
            end
            default: state_nxt = NAV;
        endcase
    end

    // Box bounds follow the registered sel_top so the pixel path is adders and compares only
    assign y_bot    = sel_top + 11'(ITEM_H);
    assign yi_top   = sel_top + 11'(FRAME_W);
    assign yi_bot   = sel_top + 11'(ITEM_H - FRAME_W);
    assign in_outer = (in.hcount >= X_L) && (in.hcount < X_R) &&
                      (in.vcount >= sel_top) && (in.vcount < y_bot);
    assign in_inner = (in.hcount >= XI_L) && (in.hcount < XI_R) &&
                      (in.vcount >= yi_top) && (in.vcount < yi_bot);

`ifdef MENU_SELECT_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BW-1:0] frame_cnt;
    logic          blink_on;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (vblnk_rise) begin
            if (frame_cnt == BW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + BW'(1);
            end
        end
    end

    assign draw_en = blink_on | (state == LOCKED);
`else
    assign draw_en = 1'b1;
`endif

    always_comb begin
        rgb_nxt = in.rgb;
        if (in.vblnk || in.hblnk)
            rgb_nxt = 12'h000;
        else if (in_outer && !in_inner && draw_en)
            rgb_nxt = FRAME_COLOR;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= NAV;
            dir_down     <= 1'b0;
            up_prev      <= 1'b0;
            down_prev    <= 1'b0;
            enter_prev   <= 1'b0;
            vblnk_prev   <= 1'b0;
            sel_idx      <= '0;
            sel_top      <= Y0_C;
            choice_valid <= 1'b0;
            choice_idx   <= '0;
            out.vcount   <= '0;
            out.vsync    <= 1'b0;
            out.vblnk    <= 1'b0;
            out.hcount   <= '0;
            out.hsync    <= 1'b0;
            out.hblnk    <= 1'b0;
            out.rgb      <= '0;
        end else begin
            state      <= state_nxt;
            dir_down   <= dir_nxt;
            up_prev    <= btn_up;
            down_prev  <= btn_down;
            enter_prev <= btn_enter;
            vblnk_prev <= in.vblnk;
            if (do_move) begin
                if (dir_down) begin
                    if (sel_idx == LAST_IDX) begin
                        sel_idx <= '0;
                        sel_top <= Y0_C;
                    end else begin
                        sel_idx <= sel_idx + IW'(1);
                        sel_top <= sel_top + PITCH_C;
                    end
                end else begin
                    if (sel_idx == '0) begin
                        sel_idx <= LAST_IDX;
                        sel_top <= Y_LAST_C;
                    end else begin
                        sel_idx <= sel_idx - IW'(1);
                        sel_top <= sel_top - PITCH_C;
                    end
                end
            end
            if (do_latch) begin
                choice_idx   <= sel_idx;
                choice_valid <= 1'b1;
            end else if (do_release) begin
                choice_valid <= 1'b0;
            end
            out.vcount <= in.vcount;
            out.vsync  <= in.vsync;
            out.vblnk  <= in.vblnk;
            out.hcount <= in.hcount;
            out.hsync  <= in.hsync;
            out.hblnk  <= in.hblnk;
            out.rgb    <= rgb_nxt;
        end
    end
endmodule

// File: tb/tb_menu_select.sv
// tb/tb_menu_select.sv - directed self-checking bench for menu_select
module tb_menu_select;
    logic       clk = 1'b0;
    logic       rst_n, btn_up, btn_down, btn_enter, choice_ack;
    logic       choice_valid;
    logic [1:0] choice_idx;
    logic [11:0] px;
    int checks = 0;
    int errors = 0;

    vga_if vin();
    vga_if vout();

    always #5 clk = ~clk;

    menu_select dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter),
        .choice_ack(choice_ack), .choice_valid(choice_valid), .choice_idx(choice_idx),
        .in(vin), .out(vout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic get_pix(input logic [10:0] x, input logic [10:0] y, input logic [11:0] c,
                           output logic [11:0] o);
        vin.hcount = x; vin.vcount = y; vin.rgb = c;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        step();
        o = vout.rgb;
    endtask

    task automatic vblank_pulse();
        vin.vblnk = 1'b1; step();
        vin.vblnk = 1'b0; step();
    endtask

    task automatic pulse_up();    btn_up = 1'b1;    step(); btn_up = 1'b0;    step(); endtask
    task automatic pulse_down();  btn_down = 1'b1;  step(); btn_down = 1'b0;  step(); endtask
    task automatic pulse_enter(); btn_enter = 1'b1; step(); btn_enter = 1'b0; step(); endtask

    task automatic test_reset();
        logic [10:0] xs [8] = '{11'd312, 11'd316, 11'd311, 11'd711, 11'd712, 11'd315, 11'd316, 11'd500};
        logic [10:0] ys [8] = '{11'd200, 11'd204, 11'd200, 11'd263, 11'd200, 11'd204, 11'd203, 11'd264};
        logic        fr [8] = '{1'b1,    1'b0,    1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0};
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vin.hcount = 11'($urandom); vin.vcount = 11'($urandom); vin.rgb = 12'($urandom);
            vin.hsync = 1'b1; vin.vsync = 1'b1; vin.hblnk = 1'b1; vin.vblnk = 1'b1;
            step();
        end
        checks++;
        if ({vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk, vout.rgb} !== 38'd0) begin
            errors++;
            $display("FAIL reset_out got vc=%0d hc=%0d rgb=%h exp all 0", vout.vcount, vout.hcount, vout.rgb);
        end
        checks++;
        if ({choice_valid, choice_idx} !== 3'b000) begin
            errors++;
            $display("FAIL reset_choice got valid=%0b idx=%0d exp 0/0", choice_valid, choice_idx);
        end
        vin.vblnk = 1'b0; vin.hblnk = 1'b0;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            get_pix(xs[i], ys[i], 12'h5A3, px);
            checks++;
            if (px !== (fr[i] ? 12'hFF0 : 12'h5A3)) begin
                errors++;
                $display("FAIL reset_pix(%0d,%0d) got %h exp %h", xs[i], ys[i], px, fr[i] ? 12'hFF0 : 12'h5A3);
            end
        end
        vin.hcount = 11'd312; vin.vcount = 11'd200; vin.rgb = 12'h5A3; vin.hblnk = 1'b1;
        step();
        checks++;
        if (vout.rgb !== 12'h000) begin
            errors++;
            $display("FAIL reset_blank_pix got %h exp 000", vout.rgb);
        end
        vin.hblnk = 1'b0;
    endtask

    task automatic test_latency();
        logic [10:0] x, y;
        logic [11:0] c;
        logic        hs, vs, hb, vb;
        for (int i = 0; i < 20; i++) begin
            x = 11'($urandom_range(800, 2047)); y = 11'($urandom); c = 12'($urandom);
            hs = 1'($urandom); vs = 1'($urandom); hb = 1'($urandom); vb = 1'($urandom);
            vin.hcount = x; vin.vcount = y; vin.rgb = c;
            vin.hsync = hs; vin.vsync = vs; vin.hblnk = hb; vin.vblnk = vb;
            step();
            checks++;
            if ({vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk, vout.rgb} !==
                {y, vs, vb, x, hs, hb, ((hb | vb) ? 12'h000 : c)}) begin
                errors++;
                $display("FAIL latency[%0d] got vc=%0d hc=%0d rgb=%h exp vc=%0d hc=%0d rgb=%h",
                         i, vout.vcount, vout.hcount, vout.rgb, y, x, (hb | vb) ? 12'h000 : c);
            end
        end
        vin.vblnk = 1'b0; vin.hblnk = 1'b0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        step();
    endtask

    task automatic test_down_move();
        pulse_down();
        get_pix(11'd312, 11'd200, 12'h111, px);
        checks++;
        if (px !== 12'hFF0) begin errors++; $display("FAIL down_midframe_old got %h exp ff0", px); end
        get_pix(11'd312, 11'd296, 12'h111, px);
        checks++;
        if (px !== 12'h111) begin errors++; $display("FAIL down_midframe_new got %h exp 111", px); end
        pulse_down();
        vblank_pulse();
        get_pix(11'd312, 11'd296, 12'h111, px);
        checks++;
        if (px !== 12'hFF0) begin errors++; $display("FAIL down_after_vblnk got %h exp ff0", px); end
        get_pix(11'd312, 11'd392, 12'h111, px);
        checks++;
        if (px !== 12'h111) begin errors++; $display("FAIL down_second_ignored got %h exp 111", px); end
    endtask

    task automatic test_wrap();
        pulse_up(); vblank_pulse();
        pulse_up(); vblank_pulse();
        get_pix(11'd312, 11'd392, 12'h222, px);
        checks++;
        if (px !== 12'hFF0) begin errors++; $display("FAIL wrap_up_top got %h exp ff0", px); end
        get_pix(11'd711, 11'd455, 12'h222, px);
        checks++;
        if (px !== 12'hFF0) begin errors++; $display("FAIL wrap_up_corner got %h exp ff0", px); end
        pulse_down(); vblank_pulse();
        get_pix(11'd312, 11'd200, 12'h222, px);
        checks++;
        if (px !== 12'hFF0) begin errors++; $display("FAIL wrap_down_top got %h exp ff0", px); end
        get_pix(11'd312, 11'd392, 12'h222, px);
        checks++;
        if (px !== 12'h222) begin errors++; $display("FAIL wrap_down_old got %h exp 222", px); end
    endtask

    task automatic test_simultaneous();
        btn_up = 1'b1; btn_down = 1'b1; step();
        btn_up = 1'b0; btn_down = 1'b0; step();
        vblank_pulse();
        get_pix(11'd312, 11'd200, 12'h333, px);
        checks++;
        if (px !== 12'hFF0) begin errors++; $display("FAIL simul_no_move got %h exp ff0", px); end
    endtask

    task automatic test_locked();
        pulse_down(); vblank_pulse();
        pulse_enter();
        checks++;
        if ({choice_valid, choice_idx} !== 3'b101) begin
            errors++;
            $display("FAIL locked_enter got valid=%0b idx=%0d exp 1/1", choice_valid, choice_idx);
        end
        for (int i = 0; i < 100; i++) begin
            btn_up = (i % 10 == 0);
            vin.vblnk = (i % 20 == 5);
            step();
        end
        btn_up = 1'b0; vin.vblnk = 1'b0;
        checks++;
        if ({choice_valid, choice_idx} !== 3'b101) begin
            errors++;
            $display("FAIL locked_hold got valid=%0b idx=%0d exp 1/1", choice_valid, choice_idx);
        end
        get_pix(11'd312, 11'd296, 12'h444, px);
        checks++;
        if (px !== 12'hFF0) begin errors++; $display("FAIL locked_frame got %h exp ff0", px); end
        choice_ack = 1'b1; step(); choice_ack = 1'b0;
        checks++;
        if (choice_valid !== 1'b0) begin errors++; $display("FAIL locked_ack got valid=%0b exp 0", choice_valid); end
        pulse_down(); vblank_pulse();
        get_pix(11'd312, 11'd392, 12'h444, px);
        checks++;
        if (px !== 12'hFF0) begin errors++; $display("FAIL locked_resume got %h exp ff0", px); end
    endtask

    task automatic test_enter_discard();
        pulse_down();
        pulse_enter();
        vblank_pulse();
        checks++;
        if ({choice_valid, choice_idx} !== 3'b110) begin
            errors++;
            $display("FAIL discard_choice got valid=%0b idx=%0d exp 1/2", choice_valid, choice_idx);
        end
        get_pix(11'd312, 11'd392, 12'h555, px);
        checks++;
        if (px !== 12'hFF0) begin errors++; $display("FAIL discard_no_move got %h exp ff0", px); end
    endtask

    task automatic test_reset_locked();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        checks++;
        if ({choice_valid, choice_idx} !== 3'b000) begin
            errors++;
            $display("FAIL rst_locked got valid=%0b idx=%0d exp 0/0", choice_valid, choice_idx);
        end
        get_pix(11'd312, 11'd200, 12'h666, px);
        checks++;
        if (px !== 12'hFF0) begin errors++; $display("FAIL rst_locked_frame got %h exp ff0", px); end
    endtask

`ifdef MENU_SELECT_BLINK_EN
    task automatic test_blink();
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        for (int i = 0; i < 29; i++) vblank_pulse();
        get_pix(11'd312, 11'd200, 12'h777, px);
        checks++;
        if (px !== 12'hFF0) begin errors++; $display("FAIL blink_visible got %h exp ff0", px); end
        vblank_pulse();
        get_pix(11'd312, 11'd200, 12'h777, px);
        checks++;
        if (px !== 12'h777) begin errors++; $display("FAIL blink_hidden got %h exp 777", px); end
        pulse_enter();
        get_pix(11'd312, 11'd200, 12'h777, px);
        checks++;
        if (px !== 12'hFF0) begin errors++; $display("FAIL blink_locked got %h exp ff0", px); end
        choice_ack = 1'b1; step(); choice_ack = 1'b0;
        for (int i = 0; i < 30; i++) vblank_pulse();
        get_pix(11'd312, 11'd200, 12'h777, px);
        checks++;
        if (px !== 12'hFF0) begin errors++; $display("FAIL blink_reshow got %h exp ff0", px); end
    endtask
`endif

    initial begin
        btn_up = 1'b0; btn_down = 1'b0; btn_enter = 1'b0; choice_ack = 1'b0; rst_n = 1'b0;
        vin.hcount = '0; vin.vcount = '0; vin.rgb = '0;
        vin.hsync = 1'b0; vin.vsync = 1'b0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
        test_reset();
        test_latency();
        test_down_move();
        test_wrap();
        test_simultaneous();
        test_locked();
        test_enter_discard();
        test_reset_locked();
`ifdef MENU_SELECT_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
